// File: rtl/ff_ram_arbiter.sv
// ff_ram_arbiter: shares one byte-wide RAM (1-cycle read latency) between two
// 32-bit word requesters, cpu and dbg. A granted word access runs as four byte
// accesses, then a one-cycle ack goes back to the requester that was served.
//
// Ports
//   clk, reset            clock (rising edge), asynchronous active-high reset
//   i_cpu_adr/dat/sel/we  cpu word address, write data, byte enables, write flag
//   i_cpu_stb             cpu request, held until o_cpu_ack
//   o_cpu_rdt, o_cpu_ack  cpu read data (valid with ack on reads), completion pulse
//   i_dbg_*, o_dbg_*      identical set for the debug requester
//   o_ram_wen/waddr/wdata RAM byte write port
//   o_ram_raddr           RAM read byte address
//   i_ram_rdata           RAM read byte, valid the cycle after o_ram_raddr
module ff_ram_arbiter #(
  parameter int unsigned aw = 10,
  parameter bit          RR = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [aw-3:0] i_cpu_adr,
  input  logic [31:0]   i_cpu_dat,
  input  logic [3:0]    i_cpu_sel,
  input  logic          i_cpu_we,
  input  logic          i_cpu_stb,
  output logic [31:0]   o_cpu_rdt,
  output logic          o_cpu_ack,
  input  logic [aw-3:0] i_dbg_adr,
  input  logic [31:0]   i_dbg_dat,
  input  logic [3:0]    i_dbg_sel,
  input  logic          i_dbg_we,
  input  logic          i_dbg_stb,
  output logic [31:0]   o_dbg_rdt,
  output logic          o_dbg_ack,
  output logic          o_ram_wen,
  output logic [aw-1:0] o_ram_waddr,
  output logic [7:0]    o_ram_wdata,
  output logic [aw-1:0] o_ram_raddr,
  input  logic [7:0]    i_ram_rdata
);

  typedef enum logic [1:0] {StIdle, StWrite, StRead, StAck} state_e;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          gnt_q, gnt_d;    // owner of the current transaction, 1 = dbg
  logic          last_q, last_d;  // most recent grant, 1 = dbg
  logic [aw-3:0] adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [3:0]    sel_q, sel_d;
  logic          we_q, we_d;
  logic [23:0]   rbuf_q, rbuf_d;  // read bytes 0..2 until byte 3 arrives
  logic [31:0]   cpu_rdt_q, cpu_rdt_d;
  logic [31:0]   dbg_rdt_q, dbg_rdt_d;
  logic          pick_dbg;
  logic [1:0]    byte_idx;

  assign byte_idx = cnt_q[1:0];

  // dbg wins only when alone, or on a tie under round-robin when cpu went last.
  assign pick_dbg = i_dbg_stb & (~i_cpu_stb | (RR & ~last_q));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    adr_d     = adr_q;
    dat_d     = dat_q;
    sel_d     = sel_q;
    we_d      = we_q;
    rbuf_d    = rbuf_q;
    cpu_rdt_d = cpu_rdt_q;
    dbg_rdt_d = dbg_rdt_q;
    unique case (state_q)
      StIdle: begin
        if (i_cpu_stb || i_dbg_stb) begin
          gnt_d  = pick_dbg;
          last_d = pick_dbg;
          adr_d  = pick_dbg ? i_dbg_adr : i_cpu_adr;
          dat_d  = pick_dbg ? i_dbg_dat : i_cpu_dat;
          sel_d  = pick_dbg ? i_dbg_sel : i_cpu_sel;
          we_d   = pick_dbg ? i_dbg_we  : i_cpu_we;
          cnt_d  = 3'd0;
          state_d = (pick_dbg ? i_dbg_we : i_cpu_we) ? StWrite : StRead;
        end
      end
      StWrite: begin
        if (cnt_q == 3'd3) begin
          cnt_d   = 3'd0;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StRead: begin
        // Data for address n arrives during count n+1.
        case (cnt_q)
          3'd1:    rbuf_d[7:0]   = i_ram_rdata;
          3'd2:    rbuf_d[15:8]  = i_ram_rdata;
          3'd3:    rbuf_d[23:16] = i_ram_rdata;
          default: ;
        endcase
        if (cnt_q == 3'd4) begin
          if (gnt_q) dbg_rdt_d = {i_ram_rdata, rbuf_q};
          else       cpu_rdt_d = {i_ram_rdata, rbuf_q};
          cnt_d   = 3'd0;
          state_d = StAck;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= 3'd0;
      gnt_q     <= 1'b0;
      last_q    <= 1'b1;
      adr_q     <= '0;
      dat_q     <= '0;
      sel_q     <= '0;
      we_q      <= 1'b0;
      rbuf_q    <= '0;
      cpu_rdt_q <= '0;
      dbg_rdt_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      adr_q     <= adr_d;
      dat_q     <= dat_d;
      sel_q     <= sel_d;
      we_q      <= we_d;
      rbuf_q    <= rbuf_d;
      cpu_rdt_q <= cpu_rdt_d;
      dbg_rdt_q <= dbg_rdt_d;
    end
  end

  always_comb begin
    o_ram_wdata = 8'h00;
    unique case (byte_idx)
      2'd0: o_ram_wdata = dat_q[7:0];
      2'd1: o_ram_wdata = dat_q[15:8];
      2'd2: o_ram_wdata = dat_q[23:16];
      2'd3: o_ram_wdata = dat_q[31:24];
      default: ;
    endcase
  end

  assign o_ram_wen   = (state_q == StWrite) & sel_q[byte_idx];
  assign o_ram_waddr = {adr_q, byte_idx};
  assign o_ram_raddr = {adr_q, byte_idx};
  assign o_cpu_ack   = (state_q == StAck) & ~gnt_q;
  assign o_dbg_ack   = (state_q == StAck) & gnt_q;
  assign o_cpu_rdt   = cpu_rdt_q;
  assign o_dbg_rdt   = dbg_rdt_q;

endmodule

// File: tb/tb_ff_ram_arbiter.sv
module tb_ff_ram_arbiter;
  localparam int unsigned AW = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [AW-3:0] cpu_adr = '0, dbg_adr = '0;
  logic [31:0]   cpu_dat = '0, dbg_dat = '0;
  logic [3:0]    cpu_sel = '0, dbg_sel = '0;
  logic          cpu_we = 1'b0, dbg_we = 1'b0, cpu_stb = 1'b0, dbg_stb = 1'b0;

  logic [31:0]   cpu_rdt0, dbg_rdt0, cpu_rdt1, dbg_rdt1;
  logic          cpu_ack0, dbg_ack0, cpu_ack1, dbg_ack1;
  logic          wen0, wen1;
  logic [AW-1:0] waddr0, raddr0, waddr1, raddr1;
  logic [7:0]    wdata0, rdata0, wdata1, rdata1;
  logic [7:0]    mem0 [0:1023];
  logic [7:0]    mem1 [0:1023];

  // Round-robin instance, checked throughout.
  ff_ram_arbiter #(.aw(AW), .RR(1'b1)) dut0 (
    .clk(clk), .reset(reset),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_stb(cpu_stb), .o_cpu_rdt(cpu_rdt0), .o_cpu_ack(cpu_ack0),
    .i_dbg_adr(dbg_adr), .i_dbg_dat(dbg_dat), .i_dbg_sel(dbg_sel), .i_dbg_we(dbg_we),
    .i_dbg_stb(dbg_stb), .o_dbg_rdt(dbg_rdt0), .o_dbg_ack(dbg_ack0),
    .o_ram_wen(wen0), .o_ram_waddr(waddr0), .o_ram_wdata(wdata0),
    .o_ram_raddr(raddr0), .i_ram_rdata(rdata0)
  );

  // Fixed-priority instance, checked in the contention test.
  ff_ram_arbiter #(.aw(AW), .RR(1'b0)) dut1 (
    .clk(clk), .reset(reset),
    .i_cpu_adr(cpu_adr), .i_cpu_dat(cpu_dat), .i_cpu_sel(cpu_sel), .i_cpu_we(cpu_we),
    .i_cpu_stb(cpu_stb), .o_cpu_rdt(cpu_rdt1), .o_cpu_ack(cpu_ack1),
    .i_dbg_adr(dbg_adr), .i_dbg_dat(dbg_dat), .i_dbg_sel(dbg_sel), .i_dbg_we(dbg_we),
    .i_dbg_stb(dbg_stb), .o_dbg_rdt(dbg_rdt1), .o_dbg_ack(dbg_ack1),
    .o_ram_wen(wen1), .o_ram_waddr(waddr1), .o_ram_wdata(wdata1),
    .o_ram_raddr(raddr1), .i_ram_rdata(rdata1)
  );

  always @(posedge clk) begin
    if (wen0) mem0[waddr0] <= wdata0;
    rdata0 <= mem0[raddr0];
    if (wen1) mem1[waddr1] <= wdata1;
    rdata1 <= mem1[raddr1];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One transaction on dut0, started in an IDLE cycle (cycle 0). Request fields are
  // scrambled in cycle 1 to show the latched copy is used. Bounded to 12 cycles.
  task automatic xfer(input bit isdbg, input bit we, input logic [AW-3:0] adr,
                      input logic [31:0] dat, input logic [3:0] sel, input int drop_at,
                      output int ack_cyc, output logic [7:0] wen_mask,
                      output logic [AW-1:0] ra1, output logic [31:0] rdt,
                      output bit other_ack);
    if (isdbg) begin
      dbg_adr = adr; dbg_dat = dat; dbg_sel = sel; dbg_we = we; dbg_stb = 1'b1;
    end else begin
      cpu_adr = adr; cpu_dat = dat; cpu_sel = sel; cpu_we = we; cpu_stb = 1'b1;
    end
    ack_cyc = -1; wen_mask = '0; ra1 = '0; rdt = '0; other_ack = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) begin
        if (isdbg) begin dbg_adr = ~adr; dbg_dat = ~dat; dbg_sel = ~sel; dbg_we = ~we; end
        else       begin cpu_adr = ~adr; cpu_dat = ~dat; cpu_sel = ~sel; cpu_we = ~we; end
        ra1 = raddr0;
      end
      if (k == drop_at) begin
        if (isdbg) dbg_stb = 1'b0;
        else       cpu_stb = 1'b0;
      end
      if (wen0 && k < 8) wen_mask[k] = 1'b1;
      if (isdbg ? cpu_ack0 : dbg_ack0) other_ack = 1'b1;
      if (isdbg ? dbg_ack0 : cpu_ack0) begin
        ack_cyc = k;
        rdt = isdbg ? dbg_rdt0 : cpu_rdt0;
        break;
      end
    end
    cpu_stb = 1'b0;
    dbg_stb = 1'b0;
    @(negedge clk);
  endtask

  int            ack;
  logic [7:0]    wm;
  logic [AW-1:0] ra;
  logic [31:0]   rd;
  bit            oa;
  int            c0, d0, c1, d1, first_dbg, late_acks;

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst_cpu_ack", 32'(cpu_ack0), 32'd0);
    chk("rst_dbg_ack", 32'(dbg_ack0), 32'd0);
    chk("rst_cpu_rdt", cpu_rdt0, 32'd0);
    chk("rst_dbg_rdt", dbg_rdt0, 32'd0);
    chk("rst_wen", 32'(wen0), 32'd0);
    chk("rst_waddr", 32'(waddr0), 32'd0);
    chk("rst_raddr", 32'(raddr0), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // 1: cpu full write, adr 5 -> bytes 20..23
    xfer(1'b0, 1'b1, 8'd5, 32'hA1B2C3D4, 4'hF, 99, ack, wm, ra, rd, oa);
    chk("t1_ack_cycle", 32'(ack), 32'd5);
    chk("t1_wen_cycles", 32'(wm), 32'h1E);
    chk("t1_other_ack", 32'(oa), 32'd0);
    chk("t1_ack_pulse", 32'(cpu_ack0), 32'd0);
    chk("t1_mem", {mem0[23], mem0[22], mem0[21], mem0[20]}, 32'hA1B2C3D4);

    // 2: cpu read back
    xfer(1'b0, 1'b0, 8'd5, 32'h0, 4'h0, 99, ack, wm, ra, rd, oa);
    chk("t2_ack_cycle", 32'(ack), 32'd6);
    chk("t2_raddr_c1", 32'(ra), 32'd20);
    chk("t2_rdt", rd, 32'hA1B2C3D4);
    chk("t2_no_wen", 32'(wm), 32'd0);
    chk("t2_dbg_rdt", dbg_rdt0, 32'd0);

    // 3: dbg partial write over all-ones
    xfer(1'b0, 1'b1, 8'd7, 32'hFFFFFFFF, 4'hF, 99, ack, wm, ra, rd, oa);
    chk("t3_fill_ack", 32'(ack), 32'd5);
    xfer(1'b1, 1'b1, 8'd7, 32'h11223344, 4'b0101, 99, ack, wm, ra, rd, oa);
    chk("t3_ack_cycle", 32'(ack), 32'd5);
    chk("t3_wen_cycles", 32'(wm), 32'h0A);
    chk("t3_other_ack", 32'(oa), 32'd0);
    xfer(1'b1, 1'b0, 8'd7, 32'h0, 4'hF, 99, ack, wm, ra, rd, oa);
    chk("t3_rd_ack", 32'(ack), 32'd6);
    chk("t3_rdt", rd, 32'hFF22FF44);
    chk("t3_cpu_rdt_kept", cpu_rdt0, 32'hA1B2C3D4);

    // 4: simultaneous held requests; dut0 round-robin, dut1 fixed priority
    cpu_adr = 8'd50; cpu_dat = 32'h01020304; cpu_sel = 4'hF; cpu_we = 1'b1;
    dbg_adr = 8'd60; dbg_dat = 32'h05060708; dbg_sel = 4'hF; dbg_we = 1'b1;
    cpu_stb = 1'b1; dbg_stb = 1'b1;
    c0 = 0; d0 = 0; c1 = 0; d1 = 0; first_dbg = -1;
    for (int k = 0; k < 18; k++) begin
      if (k > 0) @(negedge clk);
      if (cpu_ack0) c0++;
      if (dbg_ack0) begin
        d0++;
        if (first_dbg < 0) first_dbg = k;
      end
      if (cpu_ack1) c1++;
      if (dbg_ack1) d1++;
    end
    cpu_stb = 1'b0; dbg_stb = 1'b0;
    @(negedge clk);
    chk("t4_rr_cpu_acks", 32'(c0), 32'd2);
    chk("t4_rr_dbg_acks", 32'(d0), 32'd1);
    chk("t4_rr_dbg_cycle", 32'(first_dbg), 32'd11);
    chk("t4_fp_cpu_acks", 32'(c1), 32'd3);
    chk("t4_fp_dbg_acks", 32'(d1), 32'd0);

    // 5: reset during write byte 2
    xfer(1'b0, 1'b1, 8'd9, 32'h55555555, 4'hF, 99, ack, wm, ra, rd, oa);
    chk("t5_fill_ack", 32'(ack), 32'd5);
    cpu_adr = 8'd9; cpu_dat = 32'hAABBCCDD; cpu_sel = 4'hF; cpu_we = 1'b1; cpu_stb = 1'b1;
    repeat (3) @(negedge clk);
    chk("t5_wen_before", 32'(wen0), 32'd1);
    chk("t5_waddr_before", 32'(waddr0), 32'd38);
    reset = 1'b1;
    #1;
    chk("t5_wen_dropped", 32'(wen0), 32'd0);
    chk("t5_waddr_reset", 32'(waddr0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    cpu_stb = 1'b0;
    late_acks = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (cpu_ack0 || dbg_ack0) late_acks++;
    end
    chk("t5_no_ack", 32'(late_acks), 32'd0);
    chk("t5_rdt_cleared", cpu_rdt0, 32'd0);
    xfer(1'b0, 1'b0, 8'd9, 32'h0, 4'hF, 99, ack, wm, ra, rd, oa);
    chk("t5_rd_ack", 32'(ack), 32'd6);
    chk("t5_partial", rd, 32'h5555CCDD);

    // 6: stb dropped in cycle 2 of a read
    xfer(1'b0, 1'b0, 8'd5, 32'h0, 4'h0, 2, ack, wm, ra, rd, oa);
    chk("t6_ack_cycle", 32'(ack), 32'd6);
    chk("t6_rdt", rd, 32'hA1B2C3D4);
    chk("t6_idle_after", 32'(cpu_ack0), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
